maxnet_job_arbiter: RTL

Front-end scheduler that shares one maxnet core (four 32-bit inputs, iterative maximum search, `done` flag) between `N_REQ` requesters. It arbitrates among pending jobs round-robin, latches the winner's four operands, pulses the core's restart line, and waits for the core's done flag. It then returns the maximum to the winning requester, or an error if the core exceeds a cycle budget. It sits between the requester fabric and the maxnet top, which it drives entirely: the core's own clear/restart line is under the arbiter's control.

---
 rtl/maxnet_job_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/maxnet_job_arbiter.sv
// Round-robin front end that time-shares one maxnet core between N_REQ requesters.
// Launches each job with a restart pulse and returns the core's maximum, or an error on cycle-budget overrun.
module maxnet_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ*4*WIDTH-1:0] req_ops_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [N_REQ-1:0]         resp_valid_o,
  output logic [WIDTH-1:0]         resp_data_o,
  output logic                     resp_err_o,
  output logic                     busy_o,
  output logic                     eng_clr_o,
  output logic [WIDTH-1:0]         eng_inp1_o,
  output logic [WIDTH-1:0]         eng_inp2_o,
  output logic [WIDTH-1:0]         eng_inp3_o,
  output logic [WIDTH-1:0]         eng_inp4_o,
  input  logic [WIDTH-1:0]         eng_max_i,
  input  logic                     eng_done_i,
  output logic [15:0]              jobs_done_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [IW-1:0]            last_q, last_d;
  logic [IW-1:0]            win_q, win_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [N_REQ-1:0]         grant_q, grant_d;
  logic [N_REQ-1:0]         resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]         resp_data_q, resp_data_d;
  logic                     resp_err_q, resp_err_d;
  logic                     busy_q, busy_d;
  logic                     eng_clr_q, eng_clr_d;
  logic [3:0][WIDTH-1:0]    inp_q, inp_d;
  logic [15:0]              jobs_q, jobs_d;

  logic [IW-1:0]            pick_s;
  logic [IW-1:0]            idx_s;
  logic [4*WIDTH-1:0]       ops_s;

  // Round-robin pick: scanning from farthest to nearest lets the requester closest after last_q win.
  always_comb begin
    pick_s = last_q;
    idx_s  = last_q;
    for (int k = N_REQ; k >= 1; k--) begin
      idx_s  = IW'((int'(last_q) + k) % N_REQ);
      pick_s = req_i[idx_s] ? idx_s : pick_s;
    end
  end

  // Operand mux for the latched winner.
  always_comb begin
    ops_s = '0;
    for (int r = 0; r < N_REQ; r++) begin
      ops_s = (win_q == IW'(r)) ? req_ops_i[r*4*WIDTH +: 4*WIDTH] : ops_s;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    win_d        = win_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    resp_valid_d = '0;
    resp_data_d  = '0;
    resp_err_d   = 1'b0;
    eng_clr_d    = 1'b0;
    inp_d        = inp_q;
    jobs_d       = jobs_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          state_d         = ST_LAUNCH;
          win_d           = pick_s;
          last_d          = pick_s;
          grant_d[pick_s] = 1'b1;
          eng_clr_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        inp_d   = ops_s;
        cnt_d   = 16'd0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // Done is checked before the budget so a same-cycle collision still succeeds.
        if (eng_done_i) begin
          state_d             = ST_RESP;
          resp_valid_d[win_q] = 1'b1;
          resp_data_d         = eng_max_i;
          jobs_d              = jobs_q + 16'd1;
        end else if (cnt_q == 16'(TIMEOUT)) begin
          state_d             = ST_RESP;
          resp_valid_d[win_q] = 1'b1;
          resp_err_d          = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_q       <= IW'(N_REQ - 1);
      win_q        <= '0;
      cnt_q        <= 16'd0;
      grant_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      eng_clr_q    <= 1'b0;
      inp_q        <= '0;
      jobs_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      busy_q       <= busy_d;
      eng_clr_q    <= eng_clr_d;
      inp_q        <= inp_d;
      jobs_q       <= jobs_d;
    end
  end

  assign grant_o      = grant_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = busy_q;
  assign eng_clr_o    = eng_clr_q;
  assign eng_inp1_o   = inp_q[0];
  assign eng_inp2_o   = inp_q[1];
  assign eng_inp3_o   = inp_q[2];
  assign eng_inp4_o   = inp_q[3];
  assign jobs_done_o  = jobs_q;

endmodule
